// File: rtl/uart_rx_oversampler_if.sv
// uart_rx_oversampler_if
//   Groups the serial input pin and the receive-side outputs of uart_rx_oversampler.
//   The modports are named for the direction of the receiver:
//     slave  : receiver side (rx in; rx_status/rx_data/frame_err/busy out)
//     master : consumer side (drives rx, observes the outputs)
//   Signals:
//     rx         raw serial line (idle high), asynchronous to sysclk
//     rx_status  1-cycle pulse, rx_data holds a new good byte
//     rx_data    last good byte, held until the next good byte
//     frame_err  1-cycle pulse, stop bit sampled low
//     busy       high while a frame is in progress
//     parity_err 1-cycle pulse, bad even parity (only with UART_RX_PARITY_EN)
interface uart_rx_oversampler_if;
    logic       rx;
    logic       rx_status;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport slave (
        input  rx,
        output rx_status,
        output rx_data,
        output frame_err,
        output busy,
        output parity_err
    );

    modport master (
        output rx,
        input  rx_status,
        input  rx_data,
        input  frame_err,
        input  busy,
        input  parity_err
    );
`else
    modport slave (
        input  rx,
        output rx_status,
        output rx_data,
        output frame_err,
        output busy
    );

    modport master (
        output rx,
        input  rx_status,
        input  rx_data,
        input  frame_err,
        input  busy
    );
`endif
endinterface

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler
//   16x-oversampling UART receiver, 8N1, LSB first, idle-high line. Two-flop input
//   synchronizer, glitch-rejecting start detection, 3-sample majority vote (samples 7,8,9)
//   and stop-bit checking. All outputs are registered.
//   Optional feature macro: UART_RX_PARITY_EN inserts an even-parity bit (8E1) and adds
//   bus.parity_err.
// Parameters:
//   DIV    sysclk cycles per oversample tick
//   OSR    oversample ticks per bit (must be 16)
//   CNT_W  width of the tick divider, 2**CNT_W > DIV
// Ports:
//   sysclk   system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      uart_rx_oversampler_if.slave (rx in; rx_status, rx_data, frame_err, busy,
//            [parity_err] out)
module uart_rx_oversampler #(
    parameter int unsigned DIV   = 651,
    parameter int unsigned OSR   = 16,
    parameter int unsigned CNT_W = 10
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    uart_rx_oversampler_if.slave   bus
);

    localparam logic [CNT_W-1:0] DivLast = CNT_W'(DIV - 1);
    localparam logic [3:0]       SmpLast = 4'(OSR - 1);
    localparam logic [3:0]       SmpVote = 4'd9;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] div_cnt_q;
    logic [3:0]       smp_q;
    logic [2:0]       bit_idx_q;
    // Only samples 7 and 8 are ever read back; sample 9 is the live rx_s at the vote tick.
    logic             v7_q;
    logic             v8_q;
    logic [7:0]       sh_q;
    logic [7:0]       rx_data_q;
    logic             rx_status_q;
    logic             frame_err_q;
    logic             busy_q;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             parity_err_q;
`endif

    logic rx_s;
    logic tick;
    logic vote;

    assign rx_s = sync_q[1];
    assign tick = (div_cnt_q == DivLast);
    assign vote = (v7_q & v8_q) | (v7_q & rx_s) | (v8_q & rx_s);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sync_q       <= 2'b11;
            div_cnt_q    <= '0;
            smp_q        <= '0;
            bit_idx_q    <= '0;
            v7_q         <= 1'b0;
            v8_q         <= 1'b0;
            sh_q         <= '0;
            rx_data_q    <= '0;
            rx_status_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], bus.rx};
            rx_status_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Lags the state by one cycle so busy drops the cycle after the result pulse.
            busy_q <= (state_q != StIdle);

            if (state_q == StIdle) begin
                // Divider and sample counter restart here, so the start edge sets bit phase.
                div_cnt_q <= '0;
                smp_q     <= '0;
                if (!rx_s) begin
                    state_q <= StStart;
                end
            end else begin
                div_cnt_q <= tick ? '0 : div_cnt_q + CNT_W'(1);
                if (tick) begin
                    smp_q <= (smp_q == SmpLast) ? 4'd0 : smp_q + 4'd1;
                    if (smp_q == 4'd7) v7_q <= rx_s;
                    if (smp_q == 4'd8) v8_q <= rx_s;

                    unique case (state_q)
                        StStart: begin
                            if (smp_q == SmpVote && vote) begin
                                state_q <= StIdle;
                            end else if (smp_q == SmpLast) begin
                                state_q   <= StData;
                                bit_idx_q <= '0;
                            end
                        end
                        StData: begin
                            if (smp_q == SmpVote) begin
                                sh_q <= {vote, sh_q[7:1]};
                            end
                            if (smp_q == SmpLast) begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                    state_q <= StParity;
`else
                                    state_q <= StStop;
`endif
                                end
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        StParity: begin
                            if (smp_q == SmpVote) begin
                                par_bad_q <= (vote != ^sh_q);
                            end
                            if (smp_q == SmpLast) begin
                                state_q <= StStop;
                            end
                        end
`endif
                        StStop: begin
                            // Decide at mid-bit and leave early for resync margin.
                            if (smp_q == SmpVote) begin
                                if (vote) begin
                                    rx_data_q   <= sh_q;
                                    rx_status_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                    parity_err_q <= par_bad_q;
`endif
                                end else begin
                                    frame_err_q <= 1'b1;
                                end
                                state_q <= StIdle;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign bus.rx_status = rx_status_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb_uart_rx_oversampler
//   Scoreboard bench for uart_rx_oversampler with DIV=4 (64 cycles per bit). Stimulus pushes
//   the expected result of each frame into a queue; an independent monitor pops and compares
//   whenever the receiver pulses rx_status or frame_err.
module tb_uart_rx_oversampler;

    localparam int unsigned DIV = 4;
    localparam int          BIT = 16 * DIV;

    logic sysclk  = 1'b0;
    logic reset_n = 1'b0;

    always #5 sysclk = ~sysclk;

    uart_rx_oversampler_if bus ();

    uart_rx_oversampler #(
        .DIV   (DIV),
        .OSR   (16),
        .CNT_W (3)
    ) dut (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit       is_err;
        bit [7:0] data;
        bit       par_err;
    } exp_t;

    exp_t     exp_q[$];
    bit [7:0] last_good;
    int       n_cmp;
    int       n_bad;
    logic     prev_pulse;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: compares each result pulse against the oldest expectation.
    initial prev_pulse = 1'b0;
    always @(negedge sysclk) begin : monitor
        exp_t e;
        if (reset_n && (bus.rx_status || bus.frame_err)) begin
            check("pulse_exclusive", int'(bus.rx_status & bus.frame_err), 0);
            check("busy_at_pulse", int'(bus.busy), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(bus.frame_err), -1);
            end else begin
                e = exp_q.pop_front();
                check("frame_err", int'(bus.frame_err), int'(e.is_err));
                check("rx_status", int'(bus.rx_status), int'(!e.is_err));
                check("rx_data", int'(bus.rx_data), int'(e.data));
`ifdef UART_RX_PARITY_EN
                check("parity_err", int'(bus.parity_err), int'(e.par_err));
`endif
            end
        end
        if (reset_n && prev_pulse) begin
            check("busy_fall", int'(bus.busy), 0);
        end
        prev_pulse <= reset_n && (bus.rx_status || bus.frame_err);
    end

    task automatic drive(input logic b, input int n);
        bus.rx = b;
        repeat (n) @(negedge sysclk);
    endtask

    // Reference: a frame with a high stop bit yields its byte; a low stop bit yields
    // frame_err with the previous good byte still visible.
    task automatic send_frame(input bit [7:0] d, input bit stop, input bit par,
                              input int stop_len, input int gap);
        exp_t e;
        e.is_err  = !stop;
        e.data    = stop ? d : last_good;
        e.par_err = stop && (par != ^d);
        if (stop) last_good = d;
        exp_q.push_back(e);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive(par, BIT);
`endif
        drive(stop, stop_len);
        drive(1'b1, gap);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge sysclk);
        check("queue_drain", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_status"}, int'(bus.rx_status), 0);
        check({tag, "_frame_err"}, int'(bus.frame_err), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_rx_data"}, int'(bus.rx_data), 0);
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_err"}, int'(bus.parity_err), 0);
`endif
    endtask

    initial begin : stimulus
        bit       saw_busy;
        bit [7:0] d;
        bit       stop;
        bit       par;
        n_cmp     = 0;
        n_bad     = 0;
        last_good = 8'h00;
        bus.rx    = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(negedge sysclk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        drive(1'b1, 20);

        // Good frame, then a reset in the middle of the next one.
        send_frame(8'h96, 1'b1, ^8'h96, BIT, BIT);
        wait_drain();
        drive(1'b0, BIT);
        drive(1'b1, BIT);
        drive(1'b0, BIT);
        reset_n = 1'b0;
        @(negedge sysclk);
        check_idle_outputs("midframe_reset");
        last_good = 8'h00;
        bus.rx    = 1'b1;
        repeat (5) @(negedge sysclk);
        reset_n = 1'b1;
        drive(1'b1, 20);
        send_frame(8'h55, 1'b1, ^8'h55, BIT, BIT);

        // Clean frame, then a short start glitch.
        send_frame(8'hA3, 1'b1, ^8'hA3, BIT, BIT);
        wait_drain();
        saw_busy = 1'b0;
        bus.rx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (bus.busy) saw_busy = 1'b1;
        end
        bus.rx = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge sysclk);
            if (bus.busy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", int'(saw_busy), 1);
        check("glitch_busy_end", int'(bus.busy), 0);

        // Framing error keeps the previous byte.
        send_frame(8'h3C, 1'b0, ^8'h3C, BIT, BIT);

        // Back-to-back frames with a shortened stop bit.
        send_frame(8'h01, 1'b1, ^8'h01, 40, 0);
        send_frame(8'hFF, 1'b1, ^8'hFF, BIT, BIT);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, BIT, BIT);
        send_frame(8'h07, 1'b1, 1'b1, BIT, BIT);
        wait_drain();
`endif

        // Randomized frames.
        for (int n = 0; n < 14; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = ($urandom_range(0, 2) == 0) ? !(^d) : ^d;
            send_frame(d, stop, par, BIT, 40 + int'($urandom_range(0, 60)));
        end
        wait_drain();
        repeat (200) @(negedge sysclk);
        check("no_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
